sha256_job_scheduler: RTL and testbench

Round-robin scheduler that shares one `sha256_core` among `N_REQ` requesters, each of which presents a padded 512-bit message block. For the granted requester it:
- checks that the core is idle,
- loads the block through the core's byte-wide register port,
- writes START and waits for the core's completion IRQ,
- reads back the 256-bit digest and returns it with a one-cycle done strobe.

It sits between the requester fabric and the single `sha256_core` instance and is the only master of that core's register port.

---
 rtl/sha256_sched_pkg.sv | 27 ++
 rtl/sha256_job_scheduler_rr_arbiter.sv | 35 +++
 rtl/sha256_job_scheduler.sv | 129 ++++++++++++
 tb/tb_sha256_job_scheduler.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/sha256_sched_pkg.sv
// Shared definitions for the SHA-256 job scheduler.
// Holds the sha256_core register map used by the scheduler, the status and
// command values it compares against or writes, and the scheduler state
// encoding.
package sha256_sched_pkg;

  // sha256_core register map (7-bit byte addresses)
  localparam logic [6:0] W_BASE       = 7'd0;    // message bytes 0..63
  localparam logic [6:0] STATUS_REG   = 7'd65;   // status read / command write
  localparam logic [6:0] DIGEST_START = 7'd70;   // digest bytes 70..101
  localparam logic [6:0] DIGEST_END   = 7'd101;

  // Core in INIT, ready set, start clear
  localparam logic [5:0] STATUS_READY_IDLE = 6'b00_0010;
  localparam logic [7:0] START_CMD         = 8'h01;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CHECK = 3'd1,
    ST_LOAD  = 3'd2,
    ST_START = 3'd3,
    ST_WAIT  = 3'd4,
    ST_READ  = 3'd5,
    ST_DONE  = 3'd6
  } sched_state_t;

endpackage

// File: rtl/sha256_job_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter.
// Picks the first asserted request searching from last+1 (mod N). The
// pointer itself is held by the parent so that it only advances when a grant
// is actually taken.
//   req  : request vector
//   last : index granted most recently
//   gnt  : one-hot grant (all zero when no request)
//   idx  : binary index of the granted requester
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] last,
  output logic [N-1:0]         gnt,
  output logic [$clog2(N)-1:0] idx
);

  localparam int IDX_W = $clog2(N);

  logic found;

  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    for (int i = 1; i <= N; i++) begin
      if (!found && req[IDX_W'((int'(last) + i) % N)]) begin
        found                            = 1'b1;
        gnt[IDX_W'((int'(last) + i) % N)] = 1'b1;
        idx                              = IDX_W'((int'(last) + i) % N);
      end
    end
  end

endmodule

// File: rtl/sha256_job_scheduler.sv
// Shares one sha256_core among N_REQ requesters.
// For the granted requester it waits for the core to report idle, writes the
// 64-byte block through the core's byte register port, issues START, waits
// for the completion IRQ, reads the 32 digest bytes and pulses o_done.
//   i_clk, i_rst   : clock and synchronous active-high reset
//   i_req          : per-requester level request
//   i_block        : requester k block at [k*512 +: 512], stable while granted
//   o_gnt          : one-hot grant, high from grant until the done cycle
//   o_done         : one-cycle strobe to the served requester
//   o_digest       : {H0..H7}, valid with o_done, held until the next read
//   o_busy         : high whenever a job is in progress
//   o_core_addr/o_core_data/o_core_we : core register write/read port
//   i_core_data    : core combinational read data
//   i_core_irq     : core completion interrupt
module sha256_job_scheduler
  import sha256_sched_pkg::*;
#(
  parameter int N_REQ = 4
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic [N_REQ-1:0]   i_req,
  input  logic [N_REQ*512-1:0] i_block,
  output logic [N_REQ-1:0]   o_gnt,
  output logic [N_REQ-1:0]   o_done,
  output logic [255:0]       o_digest,
  output logic               o_busy,
  output logic [6:0]         o_core_addr,
  output logic [7:0]         o_core_data,
  output logic               o_core_we,
  input  logic [7:0]         i_core_data,
  input  logic               i_core_irq
);

  localparam int IDX_W = $clog2(N_REQ);

  sched_state_t      state, state_nxt;
  logic [IDX_W-1:0]  last;
  logic [N_REQ-1:0]  gnt_q;
  logic [N_REQ-1:0]  arb_gnt;
  logic [IDX_W-1:0]  arb_idx;
  logic [5:0]        a_cnt;
  logic [4:0]        r_cnt;
  logic [511:0]      blk;

  rr_arbiter #(.N(N_REQ)) u_arb (
    .req  (i_req),
    .last (last),
    .gnt  (arb_gnt),
    .idx  (arb_idx)
  );

  // Block of the current grantee; gnt_q is one-hot so at most one term hits.
  always_comb begin
    blk = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (gnt_q[k]) blk = i_block[k*512 +: 512];
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    o_core_addr = STATUS_REG;
    o_core_data = 8'h00;
    o_core_we   = 1'b0;
    unique case (state)
      ST_IDLE:  if (|i_req) state_nxt = ST_CHECK;
      // Full 6-bit compare: the post-OUT cycle and a pending start both
      // differ from the ready pattern and must keep us here.
      ST_CHECK: if (i_core_data[5:0] == STATUS_READY_IDLE) state_nxt = ST_LOAD;
      ST_LOAD: begin
        o_core_addr = W_BASE + {1'b0, a_cnt};
        o_core_data = blk[{a_cnt, 3'b000} +: 8];
        o_core_we   = 1'b1;
        if (a_cnt == 6'd63) state_nxt = ST_START;
      end
      ST_START: begin
        o_core_data = START_CMD;
        o_core_we   = 1'b1;
        state_nxt   = ST_WAIT;
      end
      ST_WAIT:  if (i_core_irq) state_nxt = ST_READ;
      ST_READ: begin
        o_core_addr = DIGEST_START + {2'b00, r_cnt};
        if (o_core_addr == DIGEST_END) state_nxt = ST_DONE;
      end
      ST_DONE:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      last     <= IDX_W'(N_REQ - 1);
      gnt_q    <= '0;
      a_cnt    <= '0;
      r_cnt    <= '0;
      o_digest <= '0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (|i_req) begin
            gnt_q <= arb_gnt;
            last  <= arb_idx;
          end
        end
        ST_CHECK: a_cnt <= '0;
        ST_LOAD:  a_cnt <= a_cnt + 6'd1;
        ST_WAIT:  r_cnt <= '0;
        ST_READ: begin
          o_digest[{r_cnt, 3'b000} +: 8] <= i_core_data;
          r_cnt                          <= r_cnt + 5'd1;
        end
        ST_DONE:  gnt_q <= '0;
        default: ;
      endcase
    end
  end

  assign o_busy = (state != ST_IDLE);
  assign o_gnt  = (state == ST_DONE) ? '0 : gnt_q;
  assign o_done = (state == ST_DONE) ? gnt_q : '0;

endmodule

// File: tb/tb_sha256_job_scheduler.sv
module tb_sha256_job_scheduler;

  localparam int N         = 4;
  localparam int ROUND_CYC = 20;
  localparam int COOL_CYC  = 36;
  localparam int BOUND     = 4000;

  localparam logic [511:0] ABC_BLK   = {32'h61626380, 448'h0, 32'h00000018};
  localparam logic [511:0] EMPTY_BLK = {8'h80, 504'h0};
  localparam logic [255:0] ABC_DIG   =
    256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
  localparam logic [255:0] EMPTY_DIG =
    256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [N-1:0]     req = '0;
  logic [N*512-1:0] blocks = '0;
  logic [N-1:0]     o_gnt, o_done;
  logic [255:0]     o_digest;
  logic             o_busy;
  logic [6:0]       core_addr;
  logic [7:0]       core_wdata;
  logic             core_we;
  logic [7:0]       core_rdata;
  logic             core_irq;

  always #5 clk = ~clk;

  sha256_job_scheduler #(.N_REQ(N)) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_req       (req),
    .i_block     (blocks),
    .o_gnt       (o_gnt),
    .o_done      (o_done),
    .o_digest    (o_digest),
    .o_busy      (o_busy),
    .o_core_addr (core_addr),
    .o_core_data (core_wdata),
    .o_core_we   (core_we),
    .i_core_data (core_rdata),
    .i_core_irq  (core_irq)
  );

  // Core model: known digests for the two reference blocks, register map
  // with byte a at address a and digest byte r at address 70+r.
  typedef enum logic [1:0] {P_INIT, P_ROUND, P_OUT, P_COOL} ph_t;
  ph_t          ph = P_INIT;
  int           ph_cnt = 0;
  logic [511:0] wmem = '0;
  logic [255:0] dig = '0;
  logic [5:0]   status;
  int           di;

  function automatic logic [255:0] hash_of(input logic [511:0] b);
    if (b == ABC_BLK)        return ABC_DIG;
    else if (b == EMPTY_BLK) return EMPTY_DIG;
    else                     return b[511:256] ^ b[255:0];
  endfunction

  always_comb begin
    case (ph)
      P_INIT:  status = 6'b00_0010;
      P_ROUND: status = 6'b10_0011;
      default: status = 6'b00_0100;
    endcase
  end

  assign core_irq = (ph == P_OUT);

  always_comb begin
    core_rdata = 8'h00;
    di         = 0;
    if (core_addr == 7'd65) core_rdata = {2'b00, status};
    else if (core_addr >= 7'd70 && core_addr <= 7'd101) begin
      di         = (int'(core_addr) - 70) * 8;
      core_rdata = dig[di +: 8];
    end
  end

  always @(posedge clk) begin
    if (core_we && core_addr < 7'd64) wmem[{core_addr[5:0], 3'b000} +: 8] <= core_wdata;
    case (ph)
      P_INIT: if (core_we && core_addr == 7'd65 && core_wdata[0]) begin
        ph     <= P_ROUND;
        ph_cnt <= ROUND_CYC;
      end
      P_ROUND: if (ph_cnt == 1) begin
        ph  <= P_OUT;
        dig <= hash_of(wmem);
      end else ph_cnt <= ph_cnt - 1;
      P_OUT: begin
        ph     <= P_COOL;
        ph_cnt <= COOL_CYC;
      end
      default: if (ph_cnt == 1) ph <= P_INIT; else ph_cnt <= ph_cnt - 1;
    endcase
  end

  // Free-running monitors sampled on the inactive edge
  int           we_total = 0, busy_writes = 0, done_total = 0, gnt_err = 0;
  logic [N-1:0] prev_gnt = '0;

  always @(negedge clk) begin
    if (core_we) we_total++;
    if (core_we && ph != P_INIT) busy_writes++;
    if (o_done != 0) done_total++;
    if ($countones(o_gnt) > 1 || $countones(o_done) > 1) gnt_err++;
    if (!rst && prev_gnt != 0 && o_gnt != prev_gnt &&
        !(o_gnt == 0 && o_done == prev_gnt)) gnt_err++;
    prev_gnt = o_gnt;
  end

  int vectors = 0, miscompares = 0;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_gnt();
    int n = 0;
    while (o_gnt == 0 && n < BOUND) begin step(); n++; end
  endtask

  task automatic wait_done();
    int n = 0;
    while (o_done == 0 && n < BOUND) begin step(); n++; end
  endtask

  task automatic count_check(output int c);
    c = 0;
    while (!core_we && c < BOUND) begin c++; step(); end
  endtask

  initial begin
    int we0, d0, cc;
    logic [N-1:0] order [5];
    order = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

    // reset state
    rst = 1'b1;
    step(); step(); step();
    chk("rst_gnt",    256'(o_gnt), 256'(0));
    chk("rst_done",   256'(o_done), 256'(0));
    chk("rst_digest", o_digest, 256'(0));
    chk("rst_busy",   256'(o_busy), 256'(0));
    chk("rst_addr",   256'(core_addr), 256'(65));
    chk("rst_wdata",  256'(core_wdata), 256'(0));
    chk("rst_we",     256'(core_we), 256'(0));

    // "abc" on requester 0
    blocks[511:0] = ABC_BLK;
    rst = 1'b0;
    req = 4'b0001;
    step();
    chk("abc_gnt_latency", 256'(o_gnt), 256'(4'b0001));
    req = 4'b0000;
    wait_done();
    chk("abc_done",   256'(o_done), 256'(4'b0001));
    chk("abc_digest", o_digest, ABC_DIG);
    step();
    chk("abc_done_1cyc", 256'(o_done), 256'(0));

    // empty message on requester 2, count writes
    blocks[1535:1024] = EMPTY_BLK;
    we0 = we_total;
    req = 4'b0100;
    step();
    chk("empty_gnt", 256'(o_gnt), 256'(4'b0100));
    req = 4'b0000;
    wait_done();
    chk("empty_done",   256'(o_done), 256'(4'b0100));
    chk("empty_digest", o_digest, EMPTY_DIG);
    chk("empty_we_cycles", 256'(we_total - we0), 256'(65));

    // all requesting after reset: order 0,1,2,3,0
    rst = 1'b1;
    step(); step();
    rst = 1'b0;
    blocks = {EMPTY_BLK, ABC_BLK, EMPTY_BLK, ABC_BLK};
    req = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      wait_gnt();
      chk($sformatf("rr_gnt%0d", i), 256'(o_gnt), 256'(order[i]));
      if (i == 4) req = 4'b0000;
      wait_done();
      chk($sformatf("rr_done%0d", i), 256'(o_done), 256'(order[i]));
      chk($sformatf("rr_digest%0d", i), o_digest, (i % 2 == 1) ? EMPTY_DIG : ABC_DIG);
    end

    // request dropped one cycle after grant
    blocks[1023:512] = ABC_BLK;
    req = 4'b0010;
    wait_gnt();
    chk("drop_gnt", 256'(o_gnt), 256'(4'b0010));
    step();
    req = 4'b0000;
    wait_done();
    chk("drop_done",   256'(o_done), 256'(4'b0010));
    chk("drop_digest", o_digest, ABC_DIG);

    // reset during WAIT, then a fresh job must wait for the core
    blocks[511:0] = EMPTY_BLK;
    req = 4'b0001;
    wait_gnt();
    chk("rstw_gnt", 256'(o_gnt), 256'(4'b0001));
    req = 4'b0000;
    begin
      int n = 0;
      while (!core_we && n < BOUND) begin step(); n++; end
      while (core_we && n < BOUND) begin step(); n++; end
    end
    step(); step(); step();
    d0 = done_total;
    rst = 1'b1;
    step();
    chk("rstw_busy",   256'(o_busy), 256'(0));
    chk("rstw_gnt0",   256'(o_gnt), 256'(0));
    chk("rstw_we",     256'(core_we), 256'(0));
    chk("rstw_addr",   256'(core_addr), 256'(65));
    chk("rstw_digest", o_digest, 256'(0));
    step();
    rst = 1'b0;
    blocks[1535:1024] = ABC_BLK;
    req = 4'b0100;
    wait_gnt();
    chk("rstw_gnt2", 256'(o_gnt), 256'(4'b0100));
    req = 4'b0000;
    count_check(cc);
    chk("rstw_check_long", 256'(cc >= 30), 256'(1));
    chk("rstw_status_at_load", 256'(status), 256'(6'b00_0010));
    wait_done();
    chk("rstw_done",   256'(o_done), 256'(4'b0100));
    chk("rstw_digest2", o_digest, ABC_DIG);
    step();
    chk("rstw_one_strobe", 256'(done_total - d0), 256'(1));

    // back-to-back on requester 3
    blocks[2047:1536] = EMPTY_BLK;
    req = 4'b1000;
    wait_gnt();
    chk("b2b_gnt_a", 256'(o_gnt), 256'(4'b1000));
    wait_done();
    chk("b2b_digest_a", o_digest, EMPTY_DIG);
    wait_gnt();
    chk("b2b_gnt_b", 256'(o_gnt), 256'(4'b1000));
    req = 4'b0000;
    count_check(cc);
    chk("b2b_check_ge2", 256'(cc >= 2), 256'(1));
    wait_done();
    chk("b2b_done_b",   256'(o_done), 256'(4'b1000));
    chk("b2b_digest_b", o_digest, EMPTY_DIG);
    step();

    chk("no_write_while_busy", 256'(busy_writes), 256'(0));
    chk("gnt_onehot_hold",     256'(gnt_err), 256'(0));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
